// File: rtl/matmul_dma_engine.sv
// Descriptor-driven matrix multiply engine: C[m][p] = A[m][n] * B[n][p] over one memory port.
// A and B are staged in local buffers, then each C element gets one MAC pass and one store.
module matmul_dma_engine #(
    parameter int          BITS      = 8,
    parameter int          DIM       = 16,
    parameter logic [31:0] CMD_ADDR  = 32'h0A00,
    parameter logic [31:0] DESC_ADDR = 32'h0A04
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mmio_en,
    input  logic        mmio_wr_en,
    input  logic [31:0] mmio_addr,
    input  logic [31:0] mmio_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  o_dbg_state
);

    localparam int CW = $clog2(DIM + 1);
    localparam int IW = $clog2(DIM);
    localparam int PW = 2 * BITS;
    localparam int AW = 2 * BITS + $clog2(DIM);
    localparam logic [AW-1:0] SAT_MAX = AW'((64'd1 << PW) - 64'd1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_DESC   = 4'd1,
        S_CHECK  = 4'd2,
        S_ERR    = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_MAC    = 4'd6,
        S_STORE  = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t         r_state;
    logic           r_mem_req;
    logic           r_mem_we;
    logic [31:0]    r_mem_addr;
    logic [31:0]    r_mem_wdata;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic           r_sat;
    logic [31:0]    r_desc_base;
    logic [31:0]    r_desc [6];
    logic [2:0]     r_didx;
    logic           r_rd_wait;
    logic [IW-1:0]  r_i;
    logic [IW-1:0]  r_j;
    logic [IW-1:0]  r_k;
    logic [AW-1:0]  r_acc;
    logic [BITS-1:0] r_a [DIM][DIM];
    logic [BITS-1:0] r_b [DIM][DIM];

    logic           w_start;
    logic           w_desc_wr;
    logic           w_rd_done;
    logic [CW-1:0]  w_m;
    logic [CW-1:0]  w_n;
    logic [CW-1:0]  w_p;
    logic           w_i_last;
    logic           w_j_last;
    logic           w_k_last;
    logic           w_shape_bad;
    logic [PW-1:0]  w_prod;
    logic [AW-1:0]  w_acc_next;
    logic [31:0]    w_store_data;

    function automatic logic dim_bad(input logic [31:0] v);
        return (v == 32'd0) || (v > 32'(DIM));
    endfunction

    assign w_start   = mmio_en && mmio_wr_en && (mmio_addr == CMD_ADDR) && mmio_wdata[0];
    assign w_desc_wr = mmio_en && mmio_wr_en && (mmio_addr == DESC_ADDR);
    assign w_rd_done = r_rd_wait && mem_rvalid;

    // Shapes are only trusted after CHECK has rejected anything outside 1..DIM.
    assign w_m = r_desc[0][CW-1:0];
    assign w_n = r_desc[1][CW-1:0];
    assign w_p = r_desc[2][CW-1:0];
    assign w_i_last = (CW'(r_i) == (w_m - CW'(1)));
    assign w_j_last = (CW'(r_j) == (w_p - CW'(1)));
    assign w_k_last = (CW'(r_k) == (w_n - CW'(1)));
    assign w_shape_bad = dim_bad(r_desc[0]) || dim_bad(r_desc[1]) || dim_bad(r_desc[2]);

    // k == 0 restarts the sum, so no separate clear cycle is needed per element.
    assign w_prod       = PW'(r_a[r_i][r_k]) * PW'(r_b[r_k][r_j]);
    assign w_acc_next   = ((r_k == '0) ? '0 : r_acc) + AW'(w_prod);
    assign w_store_data = (r_sat && (w_acc_next > SAT_MAX)) ? 32'(SAT_MAX) : 32'(w_acc_next);

    always_ff @(posedge clk) begin
        if (r_state == S_LOAD_A && w_rd_done) r_a[r_i][r_k] <= mem_rdata[BITS-1:0];
        if (r_state == S_LOAD_B && w_rd_done) r_b[r_k][r_j] <= mem_rdata[BITS-1:0];
    end

    // Memory handshake: mem_req/we/addr/wdata stay put until mem_gnt; a granted
    // read then waits for mem_rvalid before the next request is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_sat       <= 1'b0;
            r_desc_base <= '0;
            for (int q = 0; q < 6; q++) r_desc[q] <= '0;
            r_didx      <= '0;
            r_rd_wait   <= 1'b0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_desc_wr) r_desc_base <= mmio_wdata;
            if (r_mem_req && mem_gnt && !r_mem_we) begin
                r_mem_req <= 1'b0;
                r_rd_wait <= 1'b1;
            end
            if (w_rd_done) r_rd_wait <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_DESC;
                        r_busy     <= 1'b1;
                        r_sat      <= mmio_wdata[1];
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_desc_base;
                        r_didx     <= '0;
                    end
                end
                S_DESC: begin
                    if (w_rd_done) begin
                        r_desc[r_didx] <= mem_rdata;
                        if (r_didx == 3'd5) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_didx     <= r_didx + 3'd1;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_shape_bad) begin
                        r_state <= S_ERR;
                    end else begin
                        r_state    <= S_LOAD_A;
                        r_err      <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_desc[3];
                        r_i        <= '0;
                        r_j        <= '0;
                        r_k        <= '0;
                    end
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                end
                S_LOAD_A: begin
                    if (w_rd_done) begin
                        r_mem_req <= 1'b1;
                        if (w_k_last) begin
                            r_k <= '0;
                            r_i <= r_i + 1'b1;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                        if (w_i_last && w_k_last) begin
                            r_state    <= S_LOAD_B;
                            r_mem_addr <= r_desc[4];
                            r_i        <= '0;
                            r_j        <= '0;
                        end else begin
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_rd_done) begin
                        if (w_j_last) begin
                            r_j <= '0;
                            r_k <= r_k + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                        if (w_k_last && w_j_last) begin
                            r_state    <= S_MAC;
                            r_mem_addr <= r_desc[5];
                            r_i        <= '0;
                            r_j        <= '0;
                            r_k        <= '0;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (w_k_last) begin
                        r_state     <= S_STORE;
                        r_k         <= '0;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_store_data;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_STORE: begin
                    if (mem_gnt) begin
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_mem_addr + 32'd4;
                        if (w_j_last) begin
                            r_j <= '0;
                            r_i <= r_i + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                        if (w_i_last && w_j_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_MAC;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_matmul_dma_engine.sv
// Directed bench for matmul_dma_engine: memory responder with tunable gnt/rvalid delays,
// expected C words queued per job and compared against the memory image afterwards.
module tb_matmul_dma_engine;

    localparam int          DIM       = 16;
    localparam logic [31:0] CMD_ADDR  = 32'h0A00;
    localparam logic [31:0] DESC_ADDR = 32'h0A04;
    localparam int          DESC_B    = 32'h0100;
    localparam int          A_B       = 32'h1000;
    localparam int          B_B       = 32'h2000;
    localparam int          C_B       = 32'h3000;
    localparam int          MAX_CYC   = 20000;

    logic        clk;
    logic        rst_n;
    logic        mmio_en;
    logic        mmio_wr_en;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  dbg_state;

    matmul_dma_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mmio_en     (mmio_en),
        .mmio_wr_en  (mmio_wr_en),
        .mmio_addr   (mmio_addr),
        .mmio_wdata  (mmio_wdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    // ---------------- memory model ----------------
    logic [31:0] mem [4096];
    logic [31:0] exp_q [$];
    int gnt_max  = 0;
    int rv_max   = 1;
    int done_cnt = 0;
    int wr_cnt   = 0;
    int stab_err = 0;

    initial begin
        int          gnt_wait;
        int          rd_cnt;
        logic [31:0] rd_addr;
        logic        wait_prev;
        logic [31:0] p_addr;
        logic [31:0] p_wdata;
        logic        p_we;
        gnt_wait = 0; rd_cnt = 0; rd_addr = '0; wait_prev = 1'b0;
        p_addr = '0; p_wdata = '0; p_we = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                rd_cnt = 0; gnt_wait = 0; wait_prev = 1'b0;
                continue;
            end
            if (done) done_cnt++;
            if (wait_prev && (!mem_req || mem_addr != p_addr || mem_we != p_we ||
                              (mem_we && mem_wdata != p_wdata)))
                stab_err++;
            wait_prev = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[rd_addr[13:2]];
                end
            end else if (mem_req) begin
                if (gnt_wait == 0) begin
                    mem_gnt = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[13:2]] = mem_wdata;
                        wr_cnt++;
                    end else begin
                        rd_addr = mem_addr;
                        rd_cnt  = $urandom_range(rv_max, 1);
                    end
                    gnt_wait = $urandom_range(gnt_max, 0);
                end else begin
                    gnt_wait--;
                    wait_prev = 1'b1;
                    p_addr  = mem_addr;
                    p_we    = mem_we;
                    p_wdata = mem_wdata;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mmio_en = 1'b1; mmio_wr_en = 1'b1; mmio_addr = addr; mmio_wdata = data;
        @(negedge clk);
        mmio_en = 1'b0; mmio_wr_en = 1'b0; mmio_addr = '0; mmio_wdata = '0;
    endtask

    task automatic setup_job(input int m, input int n, input int p);
        mem[DESC_B/4 + 0] = 32'(m);
        mem[DESC_B/4 + 1] = 32'(n);
        mem[DESC_B/4 + 2] = 32'(p);
        mem[DESC_B/4 + 3] = 32'(A_B);
        mem[DESC_B/4 + 4] = 32'(B_B);
        mem[DESC_B/4 + 5] = 32'(C_B);
        for (int q = 0; q <= DIM * DIM; q++) mem[C_B/4 + q] = 32'hDEAD_BEEF;
    endtask

    task automatic start_job(input logic sat);
        mmio_write(DESC_ADDR, 32'(DESC_B));
        mmio_write(CMD_ADDR, {30'd0, sat, 1'b1});
    endtask

    // Counts cycles from the start write until done, or until the engine drops busy.
    task automatic wait_end(output int cyc);
        cyc = 1;
        while (!done && busy && cyc < MAX_CYC) begin
            @(negedge clk);
            cyc++;
        end
        check("job_timeout", 32'(cyc >= MAX_CYC), 32'd0);
    endtask

    task automatic push_model(input int m, input int n, input int p, input logic sat);
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < p; j++) begin
                longint acc;
                acc = 0;
                for (int k = 0; k < n; k++)
                    acc += longint'(mem[A_B/4 + i*n + k][7:0]) * longint'(mem[B_B/4 + k*p + j][7:0]);
                if (sat && acc > 65535) acc = 65535;
                exp_q.push_back(32'(acc));
            end
        end
    endtask

    task automatic check_results(input string tag, input int count);
        for (int q = 0; q < count; q++) check(tag, mem[C_B/4 + q], exp_q.pop_front());
        check({tag, "_sentinel"}, mem[C_B/4 + count], 32'hDEAD_BEEF);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int d0;
        int w0;
        int cnt;
        mmio_en = 1'b0; mmio_wr_en = 1'b0; mmio_addr = '0; mmio_wdata = '0;
        rst_n = 1'b0;
        for (int q = 0; q < 4096; q++) mem[q] = '0;
        repeat (3) @(negedge clk);
        check("rst_req",   32'(mem_req), 32'd0);
        check("rst_we",    32'(mem_we), 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: 2x2x2, zero-wait memory, 12+1+2*(4+4)+4*3+1 = 42 cycles
        setup_job(2, 2, 2);
        mem[A_B/4+0] = 1; mem[A_B/4+1] = 2; mem[A_B/4+2] = 3; mem[A_B/4+3] = 4;
        mem[B_B/4+0] = 5; mem[B_B/4+1] = 6; mem[B_B/4+2] = 7; mem[B_B/4+3] = 8;
        exp_q.push_back(19); exp_q.push_back(22); exp_q.push_back(43); exp_q.push_back(50);
        d0 = done_cnt; w0 = wr_cnt;
        start_job(1'b0);
        wait_end(cyc);
        check("t1_cycles", 32'(cyc), 32'd42);
        check("t1_busy_at_done", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_writes", 32'(wr_cnt - w0), 32'd4);
        check("t1_idle", 32'(busy), 32'd0);
        check_results("t1_c", 4);

        // T2a: 1x1x1 255*255 with sat: 65025 is below the clamp; upper word bits ignored
        setup_job(1, 1, 1);
        mem[A_B/4] = 32'h1234_56FF; mem[B_B/4] = 32'hABCD_EFFF;
        exp_q.push_back(65025);
        start_job(1'b1);
        wait_end(cyc);
        repeat (2) @(negedge clk);
        check_results("t2a_c", 1);

        // T2b: 1x16x1 all 255, sat clamps 16*65025 to 65535
        setup_job(1, DIM, 1);
        for (int q = 0; q < DIM; q++) begin mem[A_B/4+q] = 255; mem[B_B/4+q] = 255; end
        exp_q.push_back(65535);
        start_job(1'b1);
        wait_end(cyc);
        repeat (2) @(negedge clk);
        check_results("t2b_c", 1);

        // T2c: same without sat = 1040400; 12+1+2*(16+16)+17+1 = 95 cycles
        setup_job(1, DIM, 1);
        exp_q.push_back(32'd1040400);
        start_job(1'b0);
        wait_end(cyc);
        check("t2c_cycles", 32'(cyc), 32'd95);
        repeat (2) @(negedge clk);
        check_results("t2c_c", 1);

        // T3: m=0 then n=DIM+1 rejected, then a valid job clears err
        d0 = done_cnt; w0 = wr_cnt;
        setup_job(0, 2, 2);
        start_job(1'b0);
        wait_end(cyc);
        check("t3a_cycles", 32'(cyc), 32'd15);
        check("t3a_err", 32'(err), 32'd1);
        check("t3a_state", 32'(dbg_state), 32'd0);
        setup_job(1, DIM + 1, 1);
        start_job(1'b0);
        wait_end(cyc);
        check("t3b_cycles", 32'(cyc), 32'd15);
        check("t3b_err", 32'(err), 32'd1);
        repeat (2) @(negedge clk);
        check("t3_no_writes", 32'(wr_cnt - w0), 32'd0);
        check("t3_no_done", 32'(done_cnt - d0), 32'd0);
        setup_job(1, 1, 1);
        mem[A_B/4] = 3; mem[B_B/4] = 4;
        exp_q.push_back(12);
        start_job(1'b0);
        wait_end(cyc);
        check("t3c_done", 32'(done), 32'd1);
        check("t3c_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        check_results("t3c_c", 1);

        // T4: random shapes with random gnt/rvalid latency against the reference model
        gnt_max = 5; rv_max = 5;
        for (int t = 0; t < 3; t++) begin
            int   m;
            int   n;
            int   p;
            logic sat;
            m = $urandom_range(DIM, 1); n = $urandom_range(DIM, 1); p = $urandom_range(DIM, 1);
            sat = 1'($urandom_range(1, 0));
            setup_job(m, n, p);
            for (int q = 0; q < m * n; q++) mem[A_B/4+q] = $urandom();
            for (int q = 0; q < n * p; q++) mem[B_B/4+q] = $urandom();
            push_model(m, n, p, sat);
            w0 = wr_cnt;
            start_job(sat);
            wait_end(cyc);
            check("t4_done", 32'(done), 32'd1);
            repeat (2) @(negedge clk);
            check("t4_writes", 32'(wr_cnt - w0), 32'(m * p));
            check_results("t4_c", m * p);
        end
        check("t4_stable", 32'(stab_err), 32'd0);
        gnt_max = 0; rv_max = 1;

        // T5: start and descriptor-base writes during LOAD_B leave the job untouched
        setup_job(2, 3, 2);
        mem[A_B/4+0] = 1; mem[A_B/4+1] = 2; mem[A_B/4+2] = 3;
        mem[A_B/4+3] = 4; mem[A_B/4+4] = 5; mem[A_B/4+5] = 6;
        mem[B_B/4+0] = 7; mem[B_B/4+1] = 8; mem[B_B/4+2] = 9;
        mem[B_B/4+3] = 10; mem[B_B/4+4] = 11; mem[B_B/4+5] = 12;
        exp_q.push_back(58); exp_q.push_back(64); exp_q.push_back(139); exp_q.push_back(154);
        d0 = done_cnt;
        start_job(1'b0);
        cnt = 0;
        while (dbg_state != 4'd5 && cnt < 1000) begin @(negedge clk); cnt++; end
        check("t5_reach_load_b", 32'(dbg_state), 32'd5);
        mmio_write(CMD_ADDR, 32'h3);
        mmio_write(DESC_ADDR, 32'h0200);
        wait_end(cyc);
        check("t5_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_results("t5_c", 4);

        // T6: reset during MAC aborts at once; a fresh job afterwards completes
        setup_job(2, 2, 2);
        mem[A_B/4+0] = 2; mem[A_B/4+1] = 0; mem[A_B/4+2] = 1; mem[A_B/4+3] = 3;
        mem[B_B/4+0] = 4; mem[B_B/4+1] = 1; mem[B_B/4+2] = 2; mem[B_B/4+3] = 5;
        start_job(1'b0);
        cnt = 0;
        while (dbg_state != 4'd6 && cnt < 1000) begin @(negedge clk); cnt++; end
        check("t6_reach_mac", 32'(dbg_state), 32'd6);
        w0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", 32'(dbg_state), 32'd0);
        check("t6_rst_busy",  32'(busy), 32'd0);
        check("t6_rst_req",   32'(mem_req), 32'd0);
        check("t6_rst_we",    32'(mem_we), 32'd0);
        check("t6_rst_addr",  mem_addr, 32'd0);
        check("t6_rst_wdata", mem_wdata, 32'd0);
        check("t6_rst_done",  32'(done), 32'd0);
        check("t6_rst_err",   32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_no_writes", 32'(wr_cnt - w0), 32'd0);
        exp_q.push_back(8); exp_q.push_back(2); exp_q.push_back(10); exp_q.push_back(16);
        start_job(1'b0);
        wait_end(cyc);
        check("t6_cycles", 32'(cyc), 32'd42);
        repeat (2) @(negedge clk);
        check_results("t6_c", 4);
        check("final_stable", 32'(stab_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
